// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: conditions a raw push-button and two slide switches into
// a 2-bit mux select code. In MANUAL mode each debounced press steps the code.
// In AUTO mode a prescaler steps it periodically. One-cycle strobes mark
// accepted presses and select changes.
module mux_sel_sequencer #(
    parameter int DEB_CYCLES  = 500000,
    parameter int SCAN_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    input  logic       mode_i,
    input  logic       dir_i,
    output logic [1:0] sel_o,
    output logic       sel_chg_o,
    output logic       press_o
);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Bit 0 = button, bit 1 = mode switch, bit 2 = direction switch.
    logic [2:0] raw_in;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;

    logic btn_sync;
    logic mode_sync;
    logic dir_sync;

    logic             btn_deb_reg;
    logic             btn_deb_d_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic             press_rise;
    logic             press_reg;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] scan_cnt_reg;
    logic [CNT_W-1:0] scan_cnt_next;
    logic [1:0]       sel_reg;
    logic [1:0]       sel_next;
    logic             sel_chg_reg;
    logic             step;

    assign raw_in = {dir_i, mode_i, btn_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            // Two-flop synchronizer per asynchronous input.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= raw_in[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign btn_sync  = sync_reg[0];
    assign mode_sync = sync_reg[1];
    assign dir_sync  = sync_reg[2];

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_deb_reg   <= 1'b0;
            btn_deb_d_reg <= 1'b0;
            deb_cnt_reg   <= '0;
        end else begin
            btn_deb_d_reg <= btn_deb_reg;
            if (btn_sync != btn_deb_reg) begin
                if (deb_cnt_reg == DEB_LAST) begin
                    btn_deb_reg <= btn_sync;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + CNT_ONE;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

    // Rising edge of the debounced level; the press strobe and the manual
    // select step are both registered from it so they appear together.
    assign press_rise = btn_deb_reg & ~btn_deb_d_reg;

    // Mode tracking, prescaler and step decision; a mode change suppresses any step.
    always_comb begin
        state_next    = state_reg;
        scan_cnt_next = scan_cnt_reg;
        step          = 1'b0;
        case (state_reg)
            ST_MANUAL: begin
                scan_cnt_next = '0;
                if (mode_sync) begin
                    state_next = ST_AUTO;
                end else begin
                    step = press_rise;
                end
            end
            ST_AUTO: begin
                if (!mode_sync) begin
                    state_next    = ST_MANUAL;
                    scan_cnt_next = '0;
                end else if (scan_cnt_reg == SCAN_LAST) begin
                    scan_cnt_next = '0;
                    step          = 1'b1;
                end else begin
                    scan_cnt_next = scan_cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next    = ST_MANUAL;
                scan_cnt_next = '0;
            end
        endcase

        sel_next = sel_reg;
        if (step) begin
            sel_next = dir_sync ? (sel_reg - 2'd1) : (sel_reg + 2'd1);
        end
    end

    // State, prescaler, select code and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_MANUAL;
            scan_cnt_reg <= '0;
            sel_reg      <= 2'd0;
            sel_chg_reg  <= 1'b0;
            press_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            scan_cnt_reg <= scan_cnt_next;
            sel_reg      <= sel_next;
            sel_chg_reg  <= step;
            press_reg    <= press_rise;
        end
    end

    assign sel_o     = sel_reg;
    assign sel_chg_o = sel_chg_reg;
    assign press_o   = press_reg;

endmodule
